// File: rtl/policy_deck_pkg.sv
// Shared types for the policy deck engine: command opcodes, card encodings, FSM states, LFSR taps.
// POLICY_DECK_AUTO_RESHUFFLE_EN adds the ST_RESHUF state used by the draw-time reshuffle.
package policy_deck_pkg;

  typedef enum logic [2:0] {
    OP_RESET_DECK = 3'd0,
    OP_SHUFFLE    = 3'd1,
    OP_DRAW       = 3'd2,
    OP_DISCARD    = 3'd3,
    OP_PLAY       = 3'd4,
    OP_PEEK       = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHUF
`ifdef POLICY_DECK_AUTO_RESHUFFLE_EN
    , ST_RESHUF
`endif
  } state_e;

  localparam logic [1:0]  CARD_ZERO  = 2'b00;
  localparam logic [1:0]  CARD_ONE   = 2'b11;
  localparam logic [1:0]  CARD_EMPTY = 2'b01;

  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [1:0] card_enc(input logic c);
    return c ? CARD_ONE : CARD_ZERO;
  endfunction

endpackage

// File: rtl/policy_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes the low byte used as the shuffle random value.
module policy_lfsr
  import policy_deck_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rnd_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[7:0];

endmodule

// File: rtl/policy_deck_engine.sv
// Policy deck engine: STACK/HAND/DISCARD/BOARD regions in one bit vector, valid/ready commands.
// Define POLICY_DECK_AUTO_RESHUFFLE_EN to let DRAW reshuffle the discard pile into a short stack.
module policy_deck_engine
  import policy_deck_pkg::*;
#(
  parameter int          DECK_SIZE = 17,
  parameter int          NUM_ONES  = 11,
  parameter int          HAND_SIZE = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CW        = $clog2(DECK_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [1:0]             cmd_idx,
  output logic                   done,
  output logic                   err,
  output logic [2*HAND_SIZE-1:0] hand_o,
  output logic [2*HAND_SIZE-1:0] peek_o,
  output logic [CW-1:0]          n_stack,
  output logic [CW-1:0]          n_hand,
  output logic [CW-1:0]          n_discard,
  output logic [CW-1:0]          board_zeros,
  output logic [CW-1:0]          board_ones
);

  localparam int                   AW        = $clog2(DECK_SIZE);
  localparam logic [DECK_SIZE-1:0] INIT_DECK = ~({DECK_SIZE{1'b1}} << NUM_ONES);
  localparam logic [CW-1:0]        DECK_N    = CW'(DECK_SIZE);
  localparam logic [CW-1:0]        HAND_N    = CW'(HAND_SIZE);
  localparam logic [CW-1:0]        ONE       = CW'(1);

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [1:0]             idx_q, idx_d;
  logic [CW-1:0]          i_q, i_d;
  logic [DECK_SIZE-1:0]   deck_q, deck_d;
  logic [CW-1:0]          n_stack_q, n_stack_d, n_hand_q, n_hand_d, n_discard_q, n_discard_d;
  logic [CW-1:0]          board_zeros_q, board_zeros_d, board_ones_q, board_ones_d;
  logic [2*HAND_SIZE-1:0] peek_q, peek_d;
  logic                   done_q, done_d, err_q, err_d;

  logic [7:0]             rnd;
  logic [CW-1:0]          idx_w, merged, hand_lo, hand_last, disc_last, j_w;
  logic [CW+7:0]          prod;
  logic [CW:0]            pk;
  logic [DECK_SIZE-1:0]   deck_sh;
  logic                   shuf_start;

  policy_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd_o (rnd)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    idx_d         = idx_q;
    i_d           = i_q;
    deck_d        = deck_q;
    n_stack_d     = n_stack_q;
    n_hand_d      = n_hand_q;
    n_discard_d   = n_discard_q;
    board_zeros_d = board_zeros_q;
    board_ones_d  = board_ones_q;
    peek_d        = peek_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    shuf_start    = 1'b0;
    pk            = '0;

    idx_w     = CW'(idx_q);
    merged    = n_stack_q + n_discard_q;
    hand_lo   = n_stack_q + idx_w;
    hand_last = n_stack_q + n_hand_q - ONE;
    disc_last = n_stack_q + n_hand_q + n_discard_q - ONE;
    deck_sh   = deck_q >> 1;
    // Fisher-Yates pick j = (r*(i+1))>>8 always lands in [0, i]
    prod      = (CW+8)'(rnd) * (CW+8)'(i_q + ONE);
    j_w       = CW'(prod >> 8);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          idx_d   = cmd_idx;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_RESET_DECK: begin
            deck_d        = INIT_DECK;
            n_stack_d     = DECK_N;
            n_hand_d      = '0;
            n_discard_d   = '0;
            board_zeros_d = '0;
            board_ones_d  = '0;
            peek_d        = {HAND_SIZE{CARD_EMPTY}};
          end
          OP_SHUFFLE: begin
            if (n_hand_q != '0) err_d = 1'b1;
            else                shuf_start = 1'b1;
          end
          OP_DRAW: begin
            if (n_hand_q != '0) begin
              err_d = 1'b1;
            end else if (n_stack_q >= HAND_N) begin
              n_stack_d = n_stack_q - HAND_N;
              n_hand_d  = HAND_N;
            end else begin
`ifdef POLICY_DECK_AUTO_RESHUFFLE_EN
              if (merged < HAND_N) err_d = 1'b1;
              else                 shuf_start = 1'b1;
`else
              err_d = 1'b1;
`endif
            end
          end
          OP_DISCARD: begin
            if (idx_w >= n_hand_q) begin
              err_d = 1'b1;
            end else begin
              deck_d[AW'(hand_lo)]   = deck_q[AW'(hand_last)];
              deck_d[AW'(hand_last)] = deck_q[AW'(hand_lo)];
              n_hand_d    = n_hand_q - ONE;
              n_discard_d = n_discard_q + ONE;
            end
          end
          OP_PLAY: begin
            if (idx_w >= n_hand_q) begin
              err_d = 1'b1;
            end else begin
              // Close the gap in HAND+DISCARD, then park the card at the new BOARD bottom
              for (int unsigned p = 0; p < DECK_SIZE; p++) begin
                if (CW'(p) >= hand_lo && CW'(p) < disc_last) deck_d[AW'(p)] = deck_sh[AW'(p)];
              end
              deck_d[AW'(disc_last)] = deck_q[AW'(hand_lo)];
              n_hand_d = n_hand_q - ONE;
              if (deck_q[AW'(hand_lo)]) board_ones_d  = board_ones_q + ONE;
              else                      board_zeros_d = board_zeros_q + ONE;
            end
          end
          OP_PEEK: begin
            for (int unsigned k = 0; k < HAND_SIZE; k++) begin
              pk = {1'b0, n_stack_q} + (CW+1)'(k);
              if (pk >= (CW+1)'(HAND_SIZE))
                peek_d[2*k +: 2] = card_enc(deck_q[AW'(pk - (CW+1)'(HAND_SIZE))]);
              else
                peek_d[2*k +: 2] = CARD_EMPTY;
            end
          end
          default: err_d = 1'b1;
        endcase
        if (shuf_start) begin
          n_stack_d   = merged;
          n_discard_d = '0;
          i_d         = (merged == '0) ? '0 : merged - ONE;
          state_d     = ST_SHUF;
          done_d      = 1'b0;
        end
      end

      ST_SHUF: begin
        if (i_q != '0) begin
          deck_d[AW'(i_q)] = deck_q[AW'(j_w)];
          deck_d[AW'(j_w)] = deck_q[AW'(i_q)];
        end
        if (i_q <= ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
`ifdef POLICY_DECK_AUTO_RESHUFFLE_EN
          if (op_q == OP_DRAW) begin
            state_d = ST_RESHUF;
            done_d  = 1'b0;
          end
`endif
        end else begin
          i_d = i_q - ONE;
        end
      end

`ifdef POLICY_DECK_AUTO_RESHUFFLE_EN
      ST_RESHUF: begin
        n_stack_d = n_stack_q - HAND_N;
        n_hand_d  = HAND_N;
        state_d   = ST_IDLE;
        done_d    = 1'b1;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      idx_q         <= '0;
      i_q           <= '0;
      deck_q        <= INIT_DECK;
      n_stack_q     <= DECK_N;
      n_hand_q      <= '0;
      n_discard_q   <= '0;
      board_zeros_q <= '0;
      board_ones_q  <= '0;
      peek_q        <= {HAND_SIZE{CARD_EMPTY}};
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      idx_q         <= idx_d;
      i_q           <= i_d;
      deck_q        <= deck_d;
      n_stack_q     <= n_stack_d;
      n_hand_q      <= n_hand_d;
      n_discard_q   <= n_discard_d;
      board_zeros_q <= board_zeros_d;
      board_ones_q  <= board_ones_d;
      peek_q        <= peek_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    hand_o = {HAND_SIZE{CARD_EMPTY}};
    for (int unsigned k = 0; k < HAND_SIZE; k++) begin
      if (CW'(k) < n_hand_q) hand_o[2*k +: 2] = card_enc(deck_q[AW'(n_stack_q + CW'(k))]);
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign peek_o      = peek_q;
  assign n_stack     = n_stack_q;
  assign n_hand      = n_hand_q;
  assign n_discard   = n_discard_q;
  assign board_zeros = board_zeros_q;
  assign board_ones  = board_ones_q;

endmodule

// File: tb/tb_policy_deck_engine.sv
// Self-checking bench for policy_deck_engine: directed steps plus random commands against a
// queue-based region model (stack/hand/discard/board) and an independent LFSR sequence.
module tb_policy_deck_engine;

  localparam int          DS   = 17;
  localparam int          NO   = 11;
  localparam int          HS   = 3;
  localparam int          CW   = $clog2(DS + 1);
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd_op = 3'd0;
  logic [1:0]      cmd_idx = 2'd0;
  logic            cmd_ready, done, err;
  logic [2*HS-1:0] hand_o, peek_o;
  logic [CW-1:0]   n_stack, n_hand, n_discard, board_zeros, board_ones;

  policy_deck_engine #(
    .DECK_SIZE (DS),
    .NUM_ONES  (NO),
    .HAND_SIZE (HS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .done        (done),
    .err         (err),
    .hand_o      (hand_o),
    .peek_o      (peek_o),
    .n_stack     (n_stack),
    .n_hand      (n_hand),
    .n_discard   (n_discard),
    .board_zeros (board_zeros),
    .board_ones  (board_ones)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_lat = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] tb_lfsr = SEED;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_lfsr <= SEED;
    else        tb_lfsr <= lfsr_step(tb_lfsr);
  end

  bit              st[$], hd[$], dc[$], bd[$];
  int              m_bz, m_bo;
  logic [2*HS-1:0] m_peek;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input bit c);
    return c ? 2'b11 : 2'b00;
  endfunction

  task automatic model_reset();
    st.delete(); hd.delete(); dc.delete(); bd.delete();
    for (int i = 0; i < DS; i++) st.push_back(i < NO);
    m_bz = 0; m_bo = 0;
    m_peek = {HS{2'b01}};
  endtask

  function automatic logic [DS-1:0] exp_deck();
    logic [DS-1:0] v;
    int p;
    v = '0; p = 0;
    foreach (st[i]) begin v[p] = st[i]; p++; end
    foreach (hd[i]) begin v[p] = hd[i]; p++; end
    foreach (dc[i]) begin v[p] = dc[i]; p++; end
    foreach (bd[i]) begin v[p] = bd[i]; p++; end
    return v;
  endfunction

  function automatic logic [2*HS-1:0] exp_hand();
    logic [2*HS-1:0] v;
    v = {HS{2'b01}};
    foreach (hd[k]) v[2*k +: 2] = enc(hd[k]);
    return v;
  endfunction

  task automatic m_shuffle(input logic [15:0] l0, output int lat);
    logic [15:0] l;
    int n, j;
    bit t;
    foreach (dc[i]) st.push_back(dc[i]);
    dc.delete();
    n = st.size();
    l = lfsr_step(lfsr_step(l0));
    for (int i = n - 1; i >= 1; i--) begin
      j = (int'(l[7:0]) * (i + 1)) >> 8;
      t = st[i]; st[i] = st[j]; st[j] = t;
      l = lfsr_step(l);
    end
    lat = ((n - 1 > 1) ? n - 1 : 1) + 1;
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [1:0] idx, input logic [15:0] l0,
                             output bit e_err, output int e_lat);
    bit c;
    int n;
    e_err = 1'b0;
    e_lat = 1;
    case (op)
      3'd0: model_reset();
      3'd1: if (hd.size() != 0) e_err = 1'b1; else m_shuffle(l0, e_lat);
      3'd2: begin
`ifdef POLICY_DECK_AUTO_RESHUFFLE_EN
        if (hd.size() == 0 && st.size() < HS && st.size() + dc.size() >= HS) begin
          m_shuffle(l0, e_lat);
          e_lat++;
        end
`endif
        if (hd.size() != 0 || st.size() < HS) e_err = 1'b1;
        else begin
          n = st.size();
          for (int k = 0; k < HS; k++) hd.push_back(st[n - HS + k]);
          repeat (HS) void'(st.pop_back());
        end
      end
      3'd3: begin
        if (int'(idx) >= hd.size()) e_err = 1'b1;
        else begin
          c = hd[idx]; hd[idx] = hd[hd.size() - 1]; hd[hd.size() - 1] = c;
          dc.push_front(hd.pop_back());
        end
      end
      3'd4: begin
        if (int'(idx) >= hd.size()) e_err = 1'b1;
        else begin
          c = hd[idx];
          hd.delete(int'(idx));
          bd.push_front(c);
          if (c) m_bo++; else m_bz++;
        end
      end
      3'd5: begin
        n = st.size();
        for (int k = 0; k < HS; k++)
          m_peek[2*k +: 2] = (n - HS + k >= 0) ? enc(st[n - HS + k]) : 2'b01;
      end
      default: e_err = 1'b1;
    endcase
  endtask

  task automatic compare_state(input string ctx);
    check({ctx, ":n_stack"},   64'(n_stack),     64'(st.size()));
    check({ctx, ":n_hand"},    64'(n_hand),      64'(hd.size()));
    check({ctx, ":n_discard"}, 64'(n_discard),   64'(dc.size()));
    check({ctx, ":b_zeros"},   64'(board_zeros), 64'(m_bz));
    check({ctx, ":b_ones"},    64'(board_ones),  64'(m_bo));
    check({ctx, ":hand_o"},    64'(hand_o),      64'(exp_hand()));
    check({ctx, ":peek_o"},    64'(peek_o),      64'(m_peek));
    check({ctx, ":deck"},      64'(dut.deck_q),  64'(exp_deck()));
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] idx);
    logic [15:0] l0;
    int  lat, e_lat;
    bit  got, e_err;
    string ctx;
    ctx = $sformatf("op%0d/%0d", op, idx);
    @(negedge clk);
    check({ctx, ":ready_idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
    l0 = tb_lfsr;
    @(posedge clk); #1;
    // keep valid high with a destructive op while busy: it must be ignored
    cmd_op = 3'd0; cmd_idx = 2'd0;
    check({ctx, ":ready_busy"}, 64'(cmd_ready), 64'd0);
    model_apply(op, idx, l0, e_err, e_lat);
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
    cmd_valid = 1'b0;
    last_lat = lat;
    check({ctx, ":done_seen"}, 64'(got), 64'd1);
    check({ctx, ":latency"},   64'(lat), 64'(e_lat));
    check({ctx, ":err"},       64'(err), 64'(e_err));
    compare_state(ctx);
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst:ready",   64'(cmd_ready), 64'd1);
    check("rst:done",    64'(done),      64'd0);
    check("rst:err",     64'(err),       64'd0);
    check("rst:n_stack", 64'(n_stack),   64'd17);
    check("rst:hand_o",  64'(hand_o),    64'(6'b010101));
    check("rst:peek_o",  64'(peek_o),    64'(6'b010101));
    check("rst:deck",    64'(dut.deck_q), 64'(17'h007FF));
    compare_state("rst");

    do_cmd(3'd0, 2'd0);
    do_cmd(3'd2, 2'd0);
    check("draw:lat",     64'(last_lat), 64'd1);
    check("draw:n_stack", 64'(n_stack),  64'd14);
    check("draw:hand_o",  64'(hand_o),   64'(6'b000000));
    do_cmd(3'd1, 2'd0);
    check("shuf_busyhand:err", 64'(err), 64'd1);
    do_cmd(3'd3, 2'd0);
    do_cmd(3'd4, 2'd1);
    check("play:n_hand",    64'(n_hand),    64'd1);
    check("play:n_discard", 64'(n_discard), 64'd1);
    check("play:sum", 64'(32'(n_stack) + 32'(n_hand) + 32'(n_discard) + 32'(board_zeros) + 32'(board_ones)), 64'd17);
    do_cmd(3'd3, 2'd0);
    do_cmd(3'd1, 2'd0);
    check("shuf16:lat",     64'(last_lat), 64'd16);
    check("shuf16:n_stack", 64'(n_stack),  64'd16);
    check("shuf16:ones",    64'($countones(dut.deck_q)), 64'd11);

    do_cmd(3'd0, 2'd0);
    do_cmd(3'd5, 2'd0);
    repeat (5) begin
      do_cmd(3'd2, 2'd0);
      repeat (3) do_cmd(3'd3, 2'd0);
    end
    check("drain:n_stack", 64'(n_stack), 64'd2);
    do_cmd(3'd5, 2'd0);
    do_cmd(3'd2, 2'd0);
`ifdef POLICY_DECK_AUTO_RESHUFFLE_EN
    check("short_draw:n_hand", 64'(n_hand), 64'd3);
`else
    check("short_draw:err", 64'(err), 64'd1);
`endif
    do_cmd(3'd6, 2'd0);
    do_cmd(3'd7, 2'd3);
    do_cmd(3'd0, 2'd0);
    do_cmd(3'd2, 2'd0);
    do_cmd(3'd3, 2'd3);
    do_cmd(3'd4, 2'd3);
    do_cmd(3'd4, 2'd2);
    do_cmd(3'd3, 2'd0);
    do_cmd(3'd3, 2'd0);

    do_cmd(3'd0, 2'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_idx = 2'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst:ready", 64'(cmd_ready), 64'd1);
    check("midrst:done",  64'(done),      64'd0);
    check("midrst:deck",  64'(dut.deck_q), 64'(17'h007FF));
    compare_state("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst:no_done", 64'(done), 64'd0);
    end

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 15);
      if      (r == 0)  do_cmd(3'd0, 2'($urandom_range(0, 3)));
      else if (r <= 2)  do_cmd(3'd1, 2'($urandom_range(0, 3)));
      else if (r <= 6)  do_cmd(3'd2, 2'($urandom_range(0, 3)));
      else if (r <= 10) do_cmd(3'd3, 2'($urandom_range(0, 3)));
      else if (r <= 13) do_cmd(3'd4, 2'($urandom_range(0, 3)));
      else if (r == 14) do_cmd(3'd5, 2'($urandom_range(0, 3)));
      else              do_cmd(3'($urandom_range(6, 7)), 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
